// File: rtl/dma_channel_arbiter_pkg.sv
// rtl/dma_channel_arbiter_pkg.sv - shared dma arbiter state encoding and defaults
package dma_channel_arbiter_pkg;

   localparam int ARB_NUM_CH_DEF  = 4;
   localparam int ARB_TIMEOUT_DEF = 4096;
   localparam int ARB_BUSY_CNT_W  = 16;

   typedef enum logic [2:0] {
      ARB_IDLE    = 3'd0,
      ARB_GRANT   = 3'd1,
      ARB_BUSY    = 3'd2,
      ARB_ABORT   = 3'd3,
      ARB_RELEASE = 3'd4
   } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting at ptr
module rr_picker #(
   parameter int NUM_CH = 4,
   parameter int CW     = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CW-1:0]     ptr,
   output logic [CW-1:0]     winner,
   output logic              valid
);

   logic [CW-1:0] idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = CW'((int'(ptr) + i) % NUM_CH);
         if (!valid && req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - round-robin arbiter sharing one dma_controller among NUM_CH channels
module dma_channel_arbiter
   import dma_channel_arbiter_pkg::*;
#(
   parameter int NUM_CH      = ARB_NUM_CH_DEF,
   parameter int ADD_LEN     = 16,
   parameter int DATA_LEN    = 16,
   parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_CH-1:0]             ch_rqst,
   input  logic [NUM_CH-1:0]             ch_rd_wr,
   input  logic [NUM_CH*ADD_LEN-1:0]     ch_num_words,
   input  logic [NUM_CH*(ADD_LEN+1)-1:0] ch_start_addr,
   input  logic [NUM_CH-1:0]             ch_dev_ack,
   input  logic [NUM_CH*DATA_LEN-1:0]    ch_dev_in,
   output logic [NUM_CH-1:0]             ch_grant,
   output logic [NUM_CH-1:0]             ch_dma_ack,
   output logic [NUM_CH-1:0]             ch_end_flag,
   output logic [NUM_CH-1:0]             ch_err,
   output logic [DATA_LEN-1:0]           dev_out_bcast,
   output logic                          rqst,
   output logic                          rd_wr,
   output logic [ADD_LEN-1:0]            num_words,
   output logic [ADD_LEN:0]              start_addr,
   output logic                          dev_ack,
   output logic [DATA_LEN-1:0]           dev_in,
   input  logic                          dma_ack,
   input  logic                          end_flag,
   input  logic [DATA_LEN-1:0]           dev_out,
   output logic                          ctrl_reset
);

   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [ARB_BUSY_CNT_W-1:0] TO_LAST = ARB_BUSY_CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

   arb_state_e                state_q, state_d;
   logic [CW-1:0]             owner_q, owner_d;
   logic [CW-1:0]             rr_ptr_q, rr_ptr_d;
   logic [ARB_BUSY_CNT_W-1:0] busy_cnt_q, busy_cnt_d;
   logic                      abort_cnt_q, abort_cnt_d;
   logic [NUM_CH-1:0]         err_q, err_d;
   logic [NUM_CH-1:0]         grant_q, grant_d;
   logic                      rqst_q, rqst_d;
   logic                      ctrl_reset_q, ctrl_reset_d;
   logic                      rd_wr_q, rd_wr_d;
   logic [ADD_LEN-1:0]        num_words_q, num_words_d;
   logic [ADD_LEN:0]          start_addr_q, start_addr_d;
   logic [CW-1:0]             pick_idx;
   logic                      pick_vld;
   logic                      in_xfer;

   rr_picker #(.NUM_CH(NUM_CH), .CW(CW)) u_rr_picker (
      .req    (ch_rqst),
      .ptr    (rr_ptr_q),
      .winner (pick_idx),
      .valid  (pick_vld)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      busy_cnt_d   = busy_cnt_q;
      abort_cnt_d  = abort_cnt_q;
      err_d        = err_q;
      rd_wr_d      = rd_wr_q;
      num_words_d  = num_words_q;
      start_addr_d = start_addr_q;
      case (state_q)
         ARB_IDLE: begin
            // Channel parameters are captured at grant so the controller sees them stable.
            if (pick_vld) begin
               state_d         = ARB_GRANT;
               owner_d         = pick_idx;
               err_d[pick_idx] = 1'b0;
               rd_wr_d         = ch_rd_wr[pick_idx];
               num_words_d     = ch_num_words[int'(pick_idx)*ADD_LEN +: ADD_LEN];
               start_addr_d    = ch_start_addr[int'(pick_idx)*(ADD_LEN+1) +: ADD_LEN+1];
            end
         end
         ARB_GRANT: begin
            state_d    = ARB_BUSY;
            busy_cnt_d = '0;
         end
         ARB_BUSY: begin
            busy_cnt_d = (busy_cnt_q == '1) ? busy_cnt_q : busy_cnt_q + 1'b1;
            if (end_flag) begin
               state_d = ARB_RELEASE;
            end else if (busy_cnt_q == TO_LAST) begin
               state_d        = ARB_ABORT;
               abort_cnt_d    = 1'b0;
               err_d[owner_q] = 1'b1;
            end
         end
         ARB_ABORT: begin
            abort_cnt_d = 1'b1;
            if (abort_cnt_q) state_d = ARB_RELEASE;
         end
         ARB_RELEASE: begin
            state_d      = ARB_IDLE;
            rr_ptr_d     = (owner_q == CW'(NUM_CH-1)) ? '0 : owner_q + 1'b1;
            rd_wr_d      = 1'b0;
            num_words_d  = '0;
            start_addr_d = '0;
         end
         default: state_d = ARB_IDLE;
      endcase

      grant_d      = (state_d == ARB_GRANT || state_d == ARB_BUSY || state_d == ARB_ABORT)
                     ? (ONE_HOT0 << owner_d) : '0;
      rqst_d       = (state_d == ARB_GRANT);
      ctrl_reset_d = (state_d == ARB_ABORT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ARB_IDLE;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         busy_cnt_q   <= '0;
         abort_cnt_q  <= 1'b0;
         err_q        <= '0;
         grant_q      <= '0;
         rqst_q       <= 1'b0;
         ctrl_reset_q <= 1'b1;
         rd_wr_q      <= 1'b0;
         num_words_q  <= '0;
         start_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         busy_cnt_q   <= busy_cnt_d;
         abort_cnt_q  <= abort_cnt_d;
         err_q        <= err_d;
         grant_q      <= grant_d;
         rqst_q       <= rqst_d;
         ctrl_reset_q <= ctrl_reset_d;
         rd_wr_q      <= rd_wr_d;
         num_words_q  <= num_words_d;
         start_addr_q <= start_addr_d;
      end
   end

   // Controller responses are only meaningful while a transfer is running.
   assign in_xfer       = (state_q == ARB_GRANT) || (state_q == ARB_BUSY);
   assign ch_dma_ack    = (state_q == ARB_BUSY && dma_ack)  ? grant_q : '0;
   assign ch_end_flag   = (state_q == ARB_BUSY && end_flag) ? grant_q : '0;
   assign dev_ack       = in_xfer ? ch_dev_ack[owner_q] : 1'b0;
   assign dev_in        = in_xfer ? ch_dev_in[int'(owner_q)*DATA_LEN +: DATA_LEN] : '0;
   assign dev_out_bcast = dev_out;
   assign ch_grant      = grant_q;
   assign ch_err        = err_q;
   assign rqst          = rqst_q;
   assign ctrl_reset    = ctrl_reset_q;
   assign rd_wr         = rd_wr_q;
   assign num_words     = num_words_q;
   assign start_addr    = start_addr_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - directed self-checking bench for dma_channel_arbiter
module tb_dma_channel_arbiter;

   localparam int NCH = 4;
   localparam int AL  = 16;
   localparam int DL  = 16;
   localparam int TO  = 16;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NCH-1:0]        ch_rqst, ch_rd_wr, ch_dev_ack;
   logic [NCH*AL-1:0]     ch_num_words;
   logic [NCH*(AL+1)-1:0] ch_start_addr;
   logic [NCH*DL-1:0]     ch_dev_in;
   logic [NCH-1:0]        ch_grant, ch_dma_ack, ch_end_flag, ch_err;
   logic [DL-1:0]         dev_out_bcast, dev_in, dev_out;
   logic                  rqst, rd_wr, dev_ack, dma_ack, end_flag, ctrl_reset;
   logic [AL-1:0]         num_words;
   logic [AL:0]           start_addr;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dma_channel_arbiter #(.NUM_CH(NCH), .ADD_LEN(AL), .DATA_LEN(DL), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .ch_rqst(ch_rqst), .ch_rd_wr(ch_rd_wr),
      .ch_num_words(ch_num_words), .ch_start_addr(ch_start_addr), .ch_dev_ack(ch_dev_ack),
      .ch_dev_in(ch_dev_in), .ch_grant(ch_grant), .ch_dma_ack(ch_dma_ack),
      .ch_end_flag(ch_end_flag), .ch_err(ch_err), .dev_out_bcast(dev_out_bcast),
      .rqst(rqst), .rd_wr(rd_wr), .num_words(num_words), .start_addr(start_addr),
      .dev_ack(dev_ack), .dev_in(dev_in), .dma_ack(dma_ack), .end_flag(end_flag),
      .dev_out(dev_out), .ctrl_reset(ctrl_reset)
   );

   task automatic clear_inputs();
      ch_rqst = '0; ch_rd_wr = '0; ch_dev_ack = '0; ch_num_words = '0;
      ch_start_addr = '0; ch_dev_in = '0; dma_ack = 1'b0; end_flag = 1'b0; dev_out = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic wait_rqst(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(posedge clk); #1;
         if (rqst === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      #12;
      n_chk++; if (ch_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b exp 0000", ch_grant); end
      n_chk++; if (rqst !== 1'b0) begin n_fail++; $display("FAIL reset_rqst got %b exp 0", rqst); end
      n_chk++; if (ctrl_reset !== 1'b1) begin n_fail++; $display("FAIL reset_ctrl_reset got %b exp 1", ctrl_reset); end
      n_chk++; if (ch_err !== 4'b0000) begin n_fail++; $display("FAIL reset_err got %b exp 0000", ch_err); end
      n_chk++; if (start_addr !== 17'h0) begin n_fail++; $display("FAIL reset_start_addr got %h exp 0", start_addr); end
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
      n_chk++; if (ctrl_reset !== 1'b0) begin n_fail++; $display("FAIL idle_ctrl_reset got %b exp 0", ctrl_reset); end
   endtask

   task automatic test_single();
      do_reset();
      ch_rqst = 4'b0001; ch_rd_wr = 4'b0001;
      ch_num_words[0 +: AL] = 16'd4; ch_start_addr[0 +: AL+1] = 17'h0200;
      @(posedge clk); #1;
      n_chk++; if (rqst !== 1'b1) begin n_fail++; $display("FAIL single_rqst got %b exp 1", rqst); end
      n_chk++; if (ch_grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b exp 0001", ch_grant); end
      n_chk++; if ({rd_wr, num_words, start_addr} !== {1'b1, 16'd4, 17'h0200})
         begin n_fail++; $display("FAIL single_params got %b %h %h exp 1 0004 00200", rd_wr, num_words, start_addr); end
      ch_rqst = 4'b0000;
      ch_start_addr[0 +: AL+1] = 17'h1FFF;
      ch_dev_ack = 4'b0001; ch_dev_in[0 +: DL] = 16'hABCD; ch_dev_in[DL +: DL] = 16'h1111;
      @(posedge clk); #1;
      n_chk++; if (rqst !== 1'b0) begin n_fail++; $display("FAIL single_rqst_pulse got %b exp 0", rqst); end
      n_chk++; if (start_addr !== 17'h0200) begin n_fail++; $display("FAIL single_addr_hold got %h exp 00200", start_addr); end
      n_chk++; if ({dev_ack, dev_in} !== {1'b1, 16'hABCD}) begin n_fail++; $display("FAIL single_dev_mux got %b %h exp 1 abcd", dev_ack, dev_in); end
      dma_ack = 1'b1; dev_out = 16'h5A5A; #1;
      n_chk++; if (ch_dma_ack !== 4'b0001) begin n_fail++; $display("FAIL single_dma_ack got %b exp 0001", ch_dma_ack); end
      n_chk++; if (dev_out_bcast !== 16'h5A5A) begin n_fail++; $display("FAIL single_bcast got %h exp 5a5a", dev_out_bcast); end
      dma_ack = 1'b0;
      @(posedge clk); #1;
      end_flag = 1'b1; #1;
      n_chk++; if (ch_end_flag !== 4'b0001) begin n_fail++; $display("FAIL single_end_flag got %b exp 0001", ch_end_flag); end
      @(posedge clk); #1;
      n_chk++; if (ch_grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_fall got %b exp 0000", ch_grant); end
      n_chk++; if (ch_end_flag !== 4'b0000) begin n_fail++; $display("FAIL release_end_flag got %b exp 0000", ch_end_flag); end
      n_chk++; if (dev_ack !== 1'b0) begin n_fail++; $display("FAIL release_dev_ack got %b exp 0", dev_ack); end
      end_flag = 1'b0;
      @(posedge clk); #1;
      n_chk++; if (start_addr !== 17'h0) begin n_fail++; $display("FAIL idle_start_addr got %h exp 0", start_addr); end
      n_chk++; if (ch_grant !== 4'b0000) begin n_fail++; $display("FAIL idle_no_regrant got %b exp 0000", ch_grant); end
      clear_inputs();
   endtask

   task automatic test_round_robin();
      logic [NCH-1:0] exp_g;
      bit ok;
      int order [5] = '{0, 1, 2, 3, 0};
      do_reset();
      ch_rqst = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_g = '0; exp_g[order[k]] = 1'b1;
         wait_rqst(ok);
         n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_wait_%0d got no rqst exp rqst", k); end
         n_chk++; if (ch_grant !== exp_g) begin n_fail++; $display("FAIL rr_grant_%0d got %b exp %b", k, ch_grant, exp_g); end
         @(posedge clk); #1;
         end_flag = 1'b1; #1;
         n_chk++; if (ch_end_flag !== exp_g) begin n_fail++; $display("FAIL rr_end_%0d got %b exp %b", k, ch_end_flag, exp_g); end
         @(posedge clk); #1;
         end_flag = 1'b0;
         n_chk++; if (ch_grant !== 4'b0000) begin n_fail++; $display("FAIL rr_release_%0d got %b exp 0000", k, ch_grant); end
      end
      clear_inputs();
   endtask

   task automatic test_timeout();
      bit ok;
      int n;
      do_reset();
      ch_rqst = 4'b0100;
      wait_rqst(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL to_wait got no rqst exp rqst"); end
      ch_rqst = 4'b0000;
      n = 0;
      for (int i = 0; i < 40 && ctrl_reset !== 1'b1; i++) begin
         @(posedge clk); #1;
         n++;
      end
      n_chk++; if (n - 1 !== TO) begin n_fail++; $display("FAIL to_busy_cycles got %0d exp %0d", n - 1, TO); end
      n_chk++; if (ch_err !== 4'b0100) begin n_fail++; $display("FAIL to_err got %b exp 0100", ch_err); end
      n_chk++; if (ch_grant !== 4'b0100) begin n_fail++; $display("FAIL to_abort_grant got %b exp 0100", ch_grant); end
      end_flag = 1'b1; #1;
      n_chk++; if (ch_end_flag !== 4'b0000) begin n_fail++; $display("FAIL to_abort_end got %b exp 0000", ch_end_flag); end
      @(posedge clk); #1;
      n_chk++; if (ctrl_reset !== 1'b1) begin n_fail++; $display("FAIL to_abort2 got %b exp 1", ctrl_reset); end
      end_flag = 1'b0;
      @(posedge clk); #1;
      n_chk++; if ({ctrl_reset, ch_grant} !== 5'b0_0000) begin n_fail++; $display("FAIL to_release got %b %b exp 0 0000", ctrl_reset, ch_grant); end
      n_chk++; if (ch_err !== 4'b0100) begin n_fail++; $display("FAIL to_err_sticky got %b exp 0100", ch_err); end
      ch_rqst = 4'b0100;
      wait_rqst(ok);
      n_chk++; if (ch_err !== 4'b0000) begin n_fail++; $display("FAIL to_err_clear got %b exp 0000", ch_err); end
      ch_rqst = 4'b0000;
      @(posedge clk); #1;
      end_flag = 1'b1;
      @(posedge clk); #1;
      end_flag = 1'b0;
      clear_inputs();
   endtask

   task automatic test_end_and_timeout();
      bit ok;
      do_reset();
      ch_rqst = 4'b0010;
      wait_rqst(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL tie_wait got no rqst exp rqst"); end
      repeat (TO) @(posedge clk);
      #1;
      n_chk++; if (ctrl_reset !== 1'b0) begin n_fail++; $display("FAIL tie_early_abort got %b exp 0", ctrl_reset); end
      end_flag = 1'b1; #1;
      n_chk++; if (ch_end_flag !== 4'b0010) begin n_fail++; $display("FAIL tie_end got %b exp 0010", ch_end_flag); end
      @(posedge clk); #1;
      end_flag = 1'b0;
      n_chk++; if ({ctrl_reset, ch_grant, ch_err} !== 9'b0_0000_0000)
         begin n_fail++; $display("FAIL tie_release got %b %b %b exp 0 0000 0000", ctrl_reset, ch_grant, ch_err); end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      ch_rqst = 4'b1000; ch_start_addr[3*(AL+1) +: AL+1] = 17'h1_0040;
      wait_rqst(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rst_mid_wait got no rqst exp rqst"); end
      @(posedge clk); #2;
      reset = 1'b0; end_flag = 1'b1; #1;
      n_chk++; if ({ch_grant, ch_end_flag, rqst, ctrl_reset} !== 10'b0000_0000_0_1)
         begin n_fail++; $display("FAIL rst_mid_outs got %b %b %b %b exp 0000 0000 0 1", ch_grant, ch_end_flag, rqst, ctrl_reset); end
      n_chk++; if (start_addr !== 17'h0) begin n_fail++; $display("FAIL rst_mid_addr got %h exp 0", start_addr); end
      @(posedge clk); #1;
      reset = 1'b1; end_flag = 1'b0;
      clear_inputs();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_end_and_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
